// File: rtl/config_frame_fsm_pkg.sv
// Shared types and constants for the configuration frame parser.
// Holds the FSM state encoding, the default sync pattern and the header field positions.
package config_frame_pkg;

  typedef enum logic [1:0] {
    UNSYNCED = 2'd0,
    HEADER   = 2'd1,
    DATA     = 2'd2
  } cfg_state_e;

  localparam logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1;
  localparam int          DESYNC_BIT = 20;
  localparam int          ADDR_MSB   = 31;

endpackage

// File: rtl/config_frame_fsm_if.sv
// Word-in / frame-out bus between the word assembler, the parser and the row registers.
// The slave modport is the parser's view; the master modport is the word source's view.
interface config_frame_fsm_if #(
  parameter int FrameBitsPerRow   = 32,
  parameter int RowSelectWidth    = 5,
  parameter int FrameAddressWidth = 8
);
  logic [FrameBitsPerRow-1:0]   WriteData;
  logic                         WriteStrobe;
  logic [FrameBitsPerRow-1:0]   FrameData_O;
  logic [RowSelectWidth-1:0]    RowSelect;
  logic [FrameAddressWidth-1:0] FrameAddress;
  logic                         FrameStrobe;
  logic                         ConfigActive;

  modport slave (
    input  WriteData, WriteStrobe,
    output FrameData_O, RowSelect, FrameAddress, FrameStrobe, ConfigActive
  );

  modport master (
    output WriteData, WriteStrobe,
    input  FrameData_O, RowSelect, FrameAddress, FrameStrobe, ConfigActive
  );
endinterface

// File: rtl/config_frame_fsm.sv
// Configuration word parser: hunts for the sync word, decodes frame headers and
// steers data words onto the shared row bus, then pulses FrameStrobe per frame.
module config_frame_fsm
  import config_frame_pkg::*;
#(
  parameter int          FrameBitsPerRow   = 32,
  parameter int          RowSelectWidth    = 5,
  parameter int          NumberOfRows      = 16,
  parameter int          FrameAddressWidth = 8,
  parameter int          DesyncFlagBit     = DESYNC_BIT,
  parameter logic [31:0] SyncWord          = SYNC_WORD
) (
  input  logic               CLK,
  input  logic               RESET,
  config_frame_fsm_if.slave  bus
);

  localparam logic [RowSelectWidth-1:0] LAST_ROW  = RowSelectWidth'(NumberOfRows);
  localparam logic [RowSelectWidth-1:0] FIRST_ROW = RowSelectWidth'(1);

  cfg_state_e                   state_q;
  logic                         active_q;
  logic [FrameBitsPerRow-1:0]   data_q;
  logic [RowSelectWidth-1:0]    row_q;
  logic [RowSelectWidth-1:0]    cnt_q;
  logic [FrameAddressWidth-1:0] addr_q;
  logic [FrameAddressWidth-1:0] addr_stash_q;
  logic                         stash_vld_q;
  logic                         pend_q;
  logic                         strobe_q;

  logic [FrameAddressWidth-1:0] hdr_addr_d;
  logic                         is_sync_d;

  assign hdr_addr_d = bus.WriteData[ADDR_MSB -: FrameAddressWidth];
  assign is_sync_d  = (bus.WriteData == SyncWord[FrameBitsPerRow-1:0]);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= UNSYNCED;
      active_q     <= 1'b0;
      data_q       <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      addr_stash_q <= '0;
      stash_vld_q  <= 1'b0;
      pend_q       <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      row_q    <= '0;
      strobe_q <= pend_q;
      pend_q   <= 1'b0;
      // A header accepted while the strobe is pending is applied after the pulse,
      // so FrameAddress stays stable for the whole FrameStrobe cycle.
      if (stash_vld_q) begin
        addr_q      <= addr_stash_q;
        stash_vld_q <= 1'b0;
      end
      if (bus.WriteStrobe) begin
        case (state_q)
          UNSYNCED: begin
            if (is_sync_d) begin
              state_q  <= HEADER;
              active_q <= 1'b1;
            end
          end
          HEADER: begin
            if (!is_sync_d) begin
              if (bus.WriteData[DesyncFlagBit]) begin
                state_q  <= UNSYNCED;
                active_q <= 1'b0;
              end else begin
                if (pend_q) begin
                  addr_stash_q <= hdr_addr_d;
                  stash_vld_q  <= 1'b1;
                end else begin
                  addr_q <= hdr_addr_d;
                end
                cnt_q   <= FIRST_ROW;
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            data_q <= bus.WriteData;
            row_q  <= cnt_q;
            if (cnt_q == LAST_ROW) begin
              state_q <= HEADER;
              pend_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q  <= UNSYNCED;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.FrameData_O  = data_q;
  assign bus.RowSelect    = row_q;
  assign bus.FrameAddress = addr_q;
  assign bus.FrameStrobe  = strobe_q;
  assign bus.ConfigActive = active_q;

endmodule
